m8_frame_sequencer: RTL and testbench
=====================================

Name: m8_frame_sequencer

Overview:
- Sequences the M8 word filler: generates the per-slot get-word strobe, the 10-bit read pointer (word-in-group) and the 5-bit group number.
- Captures the filler's 12-bit data word and presents it on a valid/ready stream to the downstream serializer.
- Sits between the frame-rate timing logic and the filler; it is the only driver of the filler's request inputs.

Parameters:
- WORD_DIV, 8: clk cycles per word slot; legal range 4..65535.
- PTR_W, 10: read-pointer width; a group is 2^PTR_W words.
- GRP_W, 5: group-number width; a frame is 2^GRP_W groups.
- DW, 12: data word width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request, level-sensitive.
- get_word  out  1  one-cycle fetch strobe to the filler.
- rd_pointer  out  PTR_W  word index within the current group.
- num_grp  out  GRP_W  current group number.
- fill_data  in  DW  filler output; registered by the filler, valid the cycle after get_word.
- out_word  out  DW  captured word.
- out_valid  out  1  out_word valid.
- out_ready  in  1  downstream accept.
- grp_sync  out  1  one-cycle pulse on the fetch of word 0 of any group.
- frame_sync  out  1  one-cycle pulse on the fetch of word 0 of group 0.
- overrun  out  1  sticky; a presented word was not accepted before the next slot.
- frame_cnt  out  16  completed-frame counter, wraps modulo 2^16.

Behaviour:
- Reset (reset low, async): state IDLE; all outputs 0, including rd_pointer, num_grp, out_word, overrun and frame_cnt; slot timer 0.
- States: IDLE, FETCH, CAPTURE, PRESENT, WAIT_SLOT.
- Slot timer: 16-bit. Counts 0..WORD_DIV-1 in every state except IDLE. slot_tick is asserted when timer == WORD_DIV-1; the timer then wraps to 0.
- IDLE, enable high: next cycle enters FETCH. rd_pointer=0, num_grp=0, timer=0, so the first fetch always starts a fresh frame.
- FETCH (1 cycle):
  - get_word=1 with the current rd_pointer and num_grp.
  - grp_sync=1 if rd_pointer==0.
  - frame_sync=1 if rd_pointer==0 and num_grp==0.
  - Next state: CAPTURE.
- CAPTURE (1 cycle):
  - out_word <= fill_data.
  - Pointer advances. rd_pointer+1 wraps 2^PTR_W-1 -> 0. On that wrap, num_grp+1. num_grp wraps 2^GRP_W-1 -> 0, and on that wrap frame_cnt+1.
  - Next state: PRESENT.
- PRESENT:
  - out_valid=1 and out_word held stable until accepted.
  - out_valid & out_ready with no slot_tick: out_valid drops next cycle; go to WAIT_SLOT.
  - slot_tick with no handshake: overrun <= 1, word dropped (out_valid 0 next cycle), go to FETCH.
  - slot_tick and out_ready in the same cycle: handshake counts, no overrun; go to FETCH.
- WAIT_SLOT: slot_tick -> FETCH.
- Latency: get_word to out_valid = 2 cycles. Slot period = WORD_DIV cycles, measured FETCH to FETCH.
- Stop:
  - enable low is sampled only in WAIT_SLOT, or at the PRESENT exit (handshake or tick); the block then goes to IDLE.
  - A word already in PRESENT is still offered until accepted or its slot expires.
  - rd_pointer and num_grp hold their values in IDLE.
- overrun: cleared only by reset.
- Reset mid-operation: immediate return to IDLE with all reset values; no partial handshake survives.
- get_word never asserts outside FETCH, so the filler's per-slot once-latches see exactly one strobe per pointer value.

Decomposition:
- Shared package m16_pkg:
  - state enum (IDLE, FETCH, CAPTURE, PRESENT, WAIT_SLOT);
  - PTR_W/GRP_W/DW defaults;
  - WORD_DIV_MIN=4.
- One sub-module, m8_slot_timer: modulo-WORD_DIV counter with run and clear inputs and a slot_tick output.
- Pointer/group/frame counting and the FSM stay in the top.

Test Plan (WORD_DIV=8):
1. Reset low mid-run -> all outputs 0 in the same cycle; after reset release with enable=1, the first get_word comes 1 cycle later with rd_pointer=0, num_grp=0, frame_sync=1, grp_sync=1.
2. enable=1, out_ready=1 constant, fill_data=pointer-derived pattern -> get_word every 8 cycles; out_valid 2 cycles after each get_word; out_word equals fill_data sampled the cycle after get_word; no overrun.
3. Run 1024 slots -> slot 1024 fetches rd_pointer=0, num_grp=1 with grp_sync=1 and frame_sync=0; after 32*1024 slots, frame_sync=1 and frame_cnt=1.
4. out_ready=0 for 10 cycles after the first out_valid -> overrun=1 at the next slot_tick; out_valid drops; next get_word exactly 8 cycles after the previous one; overrun stays 1.
5. out_ready asserted in the same cycle as slot_tick -> word accepted, overrun stays 0, FETCH follows next cycle.
6. enable dropped while in PRESENT, out_ready=1 two cycles later -> word accepted, then IDLE; no further get_word; rd_pointer and num_grp hold; re-enable -> restart at rd_pointer 0, num_grp 0.

Source files
------------

// File: rtl/m16_pkg.sv
// Shared types and defaults for the M8 frame sequencer.
package m16_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StPresent,
    StWaitSlot
  } seq_state_e;

  localparam int unsigned PTR_W_DEF    = 10;
  localparam int unsigned GRP_W_DEF    = 5;
  localparam int unsigned DW_DEF       = 12;
  localparam int unsigned WORD_DIV_MIN = 4;

endpackage

// File: rtl/m8_slot_timer.sv
// Modulo-WORD_DIV slot timer; slot_tick marks the last cycle of each word slot.
module m8_slot_timer #(
  parameter int unsigned WORD_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic slot_tick
);

  localparam logic [15:0] LastCount = 16'(WORD_DIV - 1);

  logic [15:0] timer_q, timer_d;

  assign slot_tick = run && (timer_q == LastCount);

  // Next count: clear wins, otherwise count and wrap while running.
  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (run) begin
      timer_d = slot_tick ? 16'd0 : timer_q + 16'd1;
    end
  end

  // Timer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/m8_frame_sequencer.sv
// M8 frame sequencer: drives the word filler's fetch strobe and pointers, captures
// the returned word and offers it on a valid/ready stream.
module m8_frame_sequencer
  import m16_pkg::*;
#(
  parameter int unsigned WORD_DIV = 8,
  parameter int unsigned PTR_W    = PTR_W_DEF,
  parameter int unsigned GRP_W    = GRP_W_DEF,
  parameter int unsigned DW       = DW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             get_word,
  output logic [PTR_W-1:0] rd_pointer,
  output logic [GRP_W-1:0] num_grp,
  input  logic [DW-1:0]    fill_data,
  output logic [DW-1:0]    out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             grp_sync,
  output logic             frame_sync,
  output logic             overrun,
  output logic [15:0]      frame_cnt
);

  seq_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic [DW-1:0]    word_q, word_d;
  logic             ovr_q, ovr_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             slot_tick;

  // Timer runs outside IDLE and is held at zero whenever IDLE is next, so every
  // start lines FETCH up with count 0.
  m8_slot_timer #(
    .WORD_DIV(WORD_DIV)
  ) u_slot_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (state_q != StIdle),
    .clear    (state_d == StIdle),
    .slot_tick(slot_tick)
  );

  // Next-state, counter updates and Moore outputs.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grp_d      = grp_q;
    word_d     = word_q;
    ovr_d      = ovr_q;
    fcnt_d     = fcnt_q;
    get_word   = 1'b0;
    grp_sync   = 1'b0;
    frame_sync = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          // Every start begins a fresh frame.
          ptr_d   = '0;
          grp_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        get_word   = 1'b1;
        grp_sync   = (ptr_q == '0);
        frame_sync = (ptr_q == '0) && (grp_q == '0);
        state_d    = StCapture;
      end
      StCapture: begin
        word_d = fill_data;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          grp_d = grp_q + 1'b1;
          if (grp_q == '1) begin
            fcnt_d = fcnt_q + 16'd1;
          end
        end
        state_d = StPresent;
      end
      StPresent: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!enable)        state_d = StIdle;
          else if (slot_tick) state_d = StFetch;
          else                state_d = StWaitSlot;
        end else if (slot_tick) begin
          // Slot expired with the word still pending: drop it.
          ovr_d   = 1'b1;
          state_d = enable ? StFetch : StIdle;
        end
      end
      StWaitSlot: begin
        if (!enable)        state_d = StIdle;
        else if (slot_tick) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grp_q   <= '0;
      word_q  <= '0;
      ovr_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grp_q   <= grp_d;
      word_q  <= word_d;
      ovr_q   <= ovr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign rd_pointer = ptr_q;
  assign num_grp    = grp_q;
  assign out_word   = word_q;
  assign overrun    = ovr_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_m8_frame_sequencer.sv
// Scoreboard bench for m8_frame_sequencer, reduced frame geometry to keep runs short.
module tb_m8_frame_sequencer;

  localparam int WD    = 8;
  localparam int PW    = 6;
  localparam int GW    = 3;
  localparam int D     = 12;
  localparam int GRP   = 1 << PW;
  localparam int FRAME = 1 << (PW + GW);

  logic          clk, reset, enable, get_word, out_valid, out_ready;
  logic          grp_sync, frame_sync, overrun;
  logic [PW-1:0] rd_pointer;
  logic [GW-1:0] num_grp;
  logic [D-1:0]  fill_data, out_word;
  logic [15:0]   frame_cnt;

  m8_frame_sequencer #(
    .WORD_DIV(WD),
    .PTR_W   (PW),
    .GRP_W   (GW),
    .DW      (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .get_word  (get_word),
    .rd_pointer(rd_pointer),
    .num_grp   (num_grp),
    .fill_data (fill_data),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grp_sync  (grp_sync),
    .frame_sync(frame_sync),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: k = words fetched since the last start, modulo a frame.
  logic [D-1:0] exp_q[$];
  int  k          = 0;
  int  frame_exp  = 0;
  int  last_fetch = 0;
  bit  restart    = 1;
  bit  exp_ovr    = 0;
  bit  expect_idle = 0;
  bit  prev_valid = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_get_word"}, get_word, 0);
    check({tag, "_rd_pointer"}, rd_pointer, 0);
    check({tag, "_num_grp"}, num_grp, 0);
    check({tag, "_out_word"}, out_word, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_grp_sync"}, grp_sync, 0);
    check({tag, "_frame_sync"}, frame_sync, 0);
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 3 * WD; i++) begin
      @(negedge clk);
      if (get_word) return;
    end
    check("wait_fetch_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 3 * WD; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    check("wait_valid_timeout", 0, 1);
  endtask

  // Filler model: returns a fresh random word the cycle after each fetch strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && get_word) begin
        fill_data = D'($urandom);
        exp_q.push_back(fill_data);
      end
    end
  end

  // Monitor: checks each fetch against the model and each presented word against the queue.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        prev_valid = 1'b0;
        continue;
      end
      if (expect_idle) check("idle_no_fetch", get_word, 0);
      if (get_word) begin
        if (restart) begin
          k       = 0;
          restart = 1'b0;
        end else begin
          check("slot_period", cyc - last_fetch, WD);
        end
        last_fetch = cyc;
        // Previous word never accepted before this slot: it was dropped.
        if (exp_q.size() > 1) begin
          void'(exp_q.pop_front());
          exp_ovr = 1'b1;
        end
        check("rd_pointer", rd_pointer, k % GRP);
        check("num_grp", num_grp, k / GRP);
        check("grp_sync", grp_sync, (k % GRP) == 0);
        check("frame_sync", frame_sync, k == 0);
        check("frame_cnt", frame_cnt, frame_exp % 65536);
        check("overrun", overrun, exp_ovr);
        k++;
        if (k == FRAME) begin
          k = 0;
          frame_exp++;
        end
      end
      if (out_valid && !prev_valid) check("valid_latency", cyc - last_fetch, 2);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", out_valid, 0);
        end else begin
          check("out_word", out_word, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  // Stimulus.
  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b1;
    fill_data = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("start_latency", get_word, 1);

    // Clean streaming with ready held high.
    repeat (40 * WD) @(negedge clk);

    // Accept exactly on the slot-tick cycle.
    wait_fetch();
    out_ready = 1'b0;
    repeat (7) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("tick_accept_fetch", get_word, 1);
    check("tick_accept_no_overrun", overrun, 0);

    // Hold ready low past the slot: word dropped, overrun sticks.
    wait_fetch();
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("overrun_set", overrun, 1);
    out_ready = 1'b1;

    // Random backpressure long enough to cross two frame boundaries.
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < 80);
    end

    // Stop while a word is presented; it must still be delivered.
    out_ready = 1'b1;
    wait_fetch();
    out_ready = 1'b0;
    wait_valid();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    expect_idle = 1'b1;
    repeat (20) @(negedge clk);
    check("stop_queue_drained", exp_q.size(), 0);
    check("stop_ptr_hold", rd_pointer, k % GRP);
    check("stop_grp_hold", num_grp, k / GRP);
    check("stop_no_valid", out_valid, 0);
    expect_idle = 1'b0;
    restart     = 1'b1;
    enable      = 1'b1;
    @(negedge clk);
    check("restart_latency", get_word, 1);
    repeat (30 * WD) @(negedge clk);

    // Asynchronous reset in the middle of a slot.
    repeat ($urandom_range(WD)) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    exp_ovr   = 1'b0;
    frame_exp = 0;
    restart   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_fetch", get_word, 1);
    repeat (20 * WD) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
